// File: rtl/axis_fifo_pkt_if.sv
// AXI-Stream channel bundle: data word, end-of-packet marker and valid/ready handshake.
// No latency; this is pure wiring.
// Backpressure is carried by TReady, which the receiving side drives.
interface axis_fifo_pkt_if #(
  parameter int width = 8
) ();
  logic [width-1:0] TData;
  logic             TValid;
  logic             TLast;
  logic             TReady;

  // Producer side drives the word; consumer side answers with TReady.
  modport master (output TData, output TValid, output TLast, input TReady);
  modport slave  (input TData, input TValid, input TLast, output TReady);
endinterface

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO with TLAST, registered FWFT output, level flags and optional store-and-forward.
// Latency: a word pushed into an empty FIFO is presented on M_TValid one cycle later.
// Backpressure: S_TReady drops only when full; a pop while full re-opens the input next cycle.
module axis_fifo_pkt #(
  parameter int depth               = 16,
  parameter int width               = 8,
  parameter int packet_mode         = 0,
  parameter int almost_full_thresh  = depth - 2,
  parameter int almost_empty_thresh = 2
) (
  input  logic                    CLK,
  input  logic                    Reset,
  axis_fifo_pkt_if.slave          s_axis,
  axis_fifo_pkt_if.master         m_axis,
  output logic [$clog2(depth):0]  count,
  output logic                    isEmpty,
  output logic                    isFull,
  output logic                    isAlmostFull,
  output logic                    isAlmostEmpty,
  output logic [$clog2(depth):0]  pktCount
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AF_C    = CW'(almost_full_thresh);
  localparam logic [CW-1:0] AE_C    = CW'(almost_empty_thresh);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} send_e;

  // Storage words are {TLast, TData}; the output register sits in front of this memory.
  logic [width:0]   mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             out_full;
  logic [width-1:0] out_dat;
  logic             out_last;
  logic [CW-1:0]    mem_cnt;
  logic             push;
  logic             pop;
  logic             load;
  logic             pkt_in;
  logic             pkt_out;
  logic             out_release;
  send_e            state_q;
  send_e            state_d;

  assign isEmpty       = (count == '0);
  assign isFull        = (count == DEPTH_C);
  assign isAlmostFull  = (count >= AF_C);
  assign isAlmostEmpty = (count <= AE_C);

  assign s_axis.TReady = !isFull && !Reset;
  assign m_axis.TData  = out_dat;
  assign m_axis.TLast  = out_last;

  assign push    = s_axis.TValid && s_axis.TReady;
  assign pop     = m_axis.TValid && m_axis.TReady;
  assign pkt_in  = push && s_axis.TLast;
  assign pkt_out = pop && m_axis.TLast;

  // Words still in memory exclude the one parked in the output register.
  assign mem_cnt = count - {{AW{1'b0}}, out_full};
  // Refill the output register when it empties or is popped; a word written this
  // same edge is not yet readable, which gives the one-cycle fall-through latency.
  assign load    = (!out_full || pop) && (mem_cnt != '0);

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {s_axis.TLast, s_axis.TData};
  end

  // Pointers, occupancy and complete-packet count.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pktCount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({pkt_in, pkt_out})
        2'b10:   pktCount <= pktCount + 1'b1;
        2'b01:   pktCount <= pktCount - 1'b1;
        default: pktCount <= pktCount;
      endcase
    end
  end

  // First-word-fall-through output register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_full <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      out_full <= 1'b1;
      {out_last, out_dat} <= mem[rd_ptr];
    end else if (pop) begin
      out_full <= 1'b0;
    end
  end

  // Sending-state register.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Enter SEND once a packet's first word is shown; leave when its TLAST pops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_axis.TValid && !pkt_out) state_d = SEND;
      SEND:    if (pkt_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output release: store-and-forward holds words back until a whole packet is in,
  // except when full (oversize packet) or while a packet is already streaming.
  always_comb begin
    out_release   = (packet_mode == 0) || (pktCount != '0) || isFull || (state_q == SEND);
    m_axis.TValid = out_full && out_release;
  end

endmodule

// File: tb/tb_axis_fifo_pkt.sv
module tb_axis_fifo_pkt;
  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  axis_fifo_pkt_if #(.width(8)) s_ct ();
  axis_fifo_pkt_if #(.width(8)) m_ct ();
  axis_fifo_pkt_if #(.width(8)) s_pm ();
  axis_fifo_pkt_if #(.width(8)) m_pm ();

  logic [3:0] count_ct, pkt_ct, count_pm, pkt_pm;
  logic empty_ct, full_ct, afull_ct, aempty_ct;
  logic empty_pm, full_pm, afull_pm, aempty_pm;

  axis_fifo_pkt #(.depth(8), .width(8), .packet_mode(0)) u_ct (
    .CLK(CLK), .Reset(Reset), .s_axis(s_ct), .m_axis(m_ct),
    .count(count_ct), .isEmpty(empty_ct), .isFull(full_ct),
    .isAlmostFull(afull_ct), .isAlmostEmpty(aempty_ct), .pktCount(pkt_ct)
  );

  axis_fifo_pkt #(.depth(8), .width(8), .packet_mode(1)) u_pm (
    .CLK(CLK), .Reset(Reset), .s_axis(s_pm), .m_axis(m_pm),
    .count(count_pm), .isEmpty(empty_pm), .isFull(full_pm),
    .isAlmostFull(afull_pm), .isAlmostEmpty(aempty_pm), .pktCount(pkt_pm)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    s_ct.TValid = 1'b0; s_ct.TData = 8'h00; s_ct.TLast = 1'b0; m_ct.TReady = 1'b0;
    s_pm.TValid = 1'b0; s_pm.TData = 8'h00; s_pm.TLast = 1'b0; m_pm.TReady = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ct_exp [3];
    logic [7:0] exp_b;
    logic       push_now;
    logic       seen;
    int         pi;
    int         ri;

    ct_exp = '{8'h11, 8'h22, 8'h33};
    idle_inputs();
    Reset = 1'b1;
    tick();
    tick();
    // Reset state, sampled while Reset is still high.
    chk("rst_rdy_low", s_ct.TReady, 1'b0);
    chk("rst_count",   count_ct,    4'd0);
    chk("rst_vld",     m_ct.TValid, 1'b0);
    chk("rst_dat",     m_ct.TData,  8'h00);
    chk("rst_empty",   empty_ct,    1'b1);
    chk("rst_full",    full_ct,     1'b0);
    chk("rst_aempty",  aempty_ct,   1'b1);
    chk("rst_afull",   afull_ct,    1'b0);
    chk("rst_pm_cnt",  count_pm,    4'd0);
    Reset = 1'b0;
    #1;
    chk("rdy_after_rst", s_ct.TReady, 1'b1);

    // Cut-through basic, including the one-cycle fall-through latency.
    s_ct.TValid = 1'b1; s_ct.TData = 8'h11;
    tick();
    chk("lat_edge_n",  m_ct.TValid, 1'b0);
    s_ct.TData = 8'h22;
    tick();
    chk("lat_edge_n1", m_ct.TValid, 1'b1);
    chk("lat_dat",     m_ct.TData,  8'h11);
    s_ct.TData = 8'h33;
    tick();
    s_ct.TValid = 1'b0;
    chk("ct_cnt3", count_ct, 4'd3);
    m_ct.TReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ct_pop_vld", m_ct.TValid, 1'b1);
      chk("ct_pop_dat", m_ct.TData,  ct_exp[i]);
      tick();
    end
    m_ct.TReady = 1'b0;
    chk("ct_empty",   empty_ct,    1'b1);
    chk("ct_vld_end", m_ct.TValid, 1'b0);
    chk("ct_cnt_end", count_ct,    4'd0);

    // Full and pointer wrap.
    s_ct.TValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_ct.TData = 8'hA0 + 8'(i);
      chk("fill_rdy", s_ct.TReady, 1'b1);
      tick();
    end
    chk("full_flag",  full_ct,     1'b1);
    chk("full_rdy",   s_ct.TReady, 1'b0);
    chk("full_afull", afull_ct,    1'b1);
    s_ct.TData = 8'hA8;
    tick();
    chk("full_9th_cnt", count_ct, 4'd8);
    s_ct.TValid = 1'b0;
    m_ct.TReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wrap_pop_a", m_ct.TData, 8'hA0 + 8'(i));
      tick();
      if (i == 0) chk("full_rdy_back", s_ct.TReady, 1'b1);
    end
    m_ct.TReady = 1'b0;
    s_ct.TValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_ct.TData = 8'hB0 + 8'(i);
      tick();
    end
    s_ct.TValid = 1'b0;
    chk("wrap_refull", full_ct, 1'b1);
    m_ct.TReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_b = (k < 5) ? 8'hA3 + 8'(k) : 8'hB0 + 8'(k - 5);
      chk("wrap_pop_vld", m_ct.TValid, 1'b1);
      chk("wrap_pop_dat", m_ct.TData,  exp_b);
      tick();
    end
    m_ct.TReady = 1'b0;
    chk("wrap_empty", empty_ct, 1'b1);

    // Simultaneous push and pop at count 4.
    s_ct.TValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_ct.TData = 8'hD0 + 8'(i);
      tick();
    end
    s_ct.TValid = 1'b1;
    m_ct.TReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_ct.TData = 8'hD4 + 8'(i);
      chk("ss_cnt", count_ct,    4'd4);
      chk("ss_vld", m_ct.TValid, 1'b1);
      chk("ss_dat", m_ct.TData,  8'hD0 + 8'(i));
      tick();
    end
    idle_inputs();
    do_reset();

    // Packet mode: held until TLAST is stored.
    m_pm.TReady = 1'b1;
    s_pm.TValid = 1'b1; s_pm.TData = 8'h01; s_pm.TLast = 1'b0;
    tick();
    chk("pm_hold1", m_pm.TValid, 1'b0);
    s_pm.TData = 8'h02;
    tick();
    chk("pm_hold2", m_pm.TValid, 1'b0);
    s_pm.TData = 8'h03; s_pm.TLast = 1'b1;
    tick();
    s_pm.TValid = 1'b0; s_pm.TLast = 1'b0;
    chk("pm_pkt1",  pkt_pm,      4'd1);
    chk("pm_vld",   m_pm.TValid, 1'b1);
    chk("pm_dat1",  m_pm.TData,  8'h01);
    chk("pm_last1", m_pm.TLast,  1'b0);
    tick();
    chk("pm_dat2",  m_pm.TData,  8'h02);
    chk("pm_last2", m_pm.TLast,  1'b0);
    tick();
    chk("pm_dat3",  m_pm.TData,  8'h03);
    chk("pm_last3", m_pm.TLast,  1'b1);
    chk("pm_pkt_b", pkt_pm,      4'd1);
    tick();
    chk("pm_pkt0",  pkt_pm,      4'd0);
    chk("pm_vld0",  m_pm.TValid, 1'b0);
    chk("pm_cnt0",  count_pm,    4'd0);

    // Oversize packet released by the full escape.
    pi = 0; ri = 0; seen = 1'b0;
    m_pm.TReady = 1'b1;
    for (int c = 0; c < 60 && ri < 10; c++) begin
      s_pm.TValid = (pi < 10);
      s_pm.TData  = 8'h40 + 8'(pi);
      s_pm.TLast  = (pi == 9);
      if (m_pm.TValid) begin
        if (!seen) begin
          seen = 1'b1;
          chk("ovf_rel_full", full_pm, 1'b1);
        end
        chk("ovf_dat",  m_pm.TData, 8'h40 + 8'(ri));
        chk("ovf_last", m_pm.TLast, (ri == 9));
        ri++;
      end
      push_now = s_pm.TValid && s_pm.TReady;
      tick();
      if (push_now) pi++;
    end
    s_pm.TValid = 1'b0; s_pm.TLast = 1'b0;
    chk("ovf_words", ri, 10);
    chk("ovf_pkt",   pkt_pm, 4'd0);
    idle_inputs();
    do_reset();

    // Reset mid-packet with a pending handshake on both sides.
    s_pm.TValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_pm.TData = 8'h60 + 8'(i);
      s_pm.TLast = (i == 2);
      tick();
    end
    s_pm.TValid = 1'b0; s_pm.TLast = 1'b0;
    tick();
    chk("mr_cnt5", count_pm, 4'd5);
    chk("mr_pkt1", pkt_pm,   4'd1);
    s_pm.TValid = 1'b1; s_pm.TData = 8'h99; m_pm.TReady = 1'b1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    s_pm.TValid = 1'b0; m_pm.TReady = 1'b0;
    #1;
    chk("mr_cnt",    count_pm,    4'd0);
    chk("mr_pkt",    pkt_pm,      4'd0);
    chk("mr_vld",    m_pm.TValid, 1'b0);
    chk("mr_empty",  empty_pm,    1'b1);
    chk("mr_dat",    m_pm.TData,  8'h00);
    chk("mr_last",   m_pm.TLast,  1'b0);
    chk("mr_aempty", aempty_pm,   1'b1);
    tick();
    chk("mr_no_xfer", count_pm, 4'd0);
    // A partial packet after reset must stay held back (sending state cleared).
    s_pm.TValid = 1'b1; s_pm.TData = 8'h77; s_pm.TLast = 1'b0; m_pm.TReady = 1'b1;
    tick();
    s_pm.TValid = 1'b0;
    tick();
    chk("mr_idle_hold", m_pm.TValid, 1'b0);
    s_pm.TValid = 1'b1; s_pm.TData = 8'h78; s_pm.TLast = 1'b1;
    tick();
    s_pm.TValid = 1'b0; s_pm.TLast = 1'b0;
    chk("mr_rel_vld", m_pm.TValid, 1'b1);
    chk("mr_rel_dat", m_pm.TData,  8'h77);
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
